// File: rtl/ffe_period_meter_pkg.sv
// Shared types and default widths for the period meter,
// the ADC capture register and the octave/pitch blocks.
package ffe_pkg;

    localparam int FFE_DATA_W = 14;
    localparam int FFE_CNT_W  = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } ffe_state_t;

endpackage

// File: rtl/ffe_period_meter_if.sv
// Sample/measurement bundle between the ADC side and the meter.
// master drives samples and enable, slave returns the period.
interface ffe_period_meter_if
#(
    parameter int DATA_W = ffe_pkg::FFE_DATA_W,
    parameter int CNT_W  = ffe_pkg::FFE_CNT_W
);

    logic              enable;
    logic [DATA_W-1:0] data_in;
    logic [CNT_W-1:0]  periodo;
    logic              period_valid;
    logic              no_signal;
    logic              sign_out;

    modport master (
        output enable,
        output data_in,
        input  periodo,
        input  period_valid,
        input  no_signal,
        input  sign_out
    );

    modport slave (
        input  enable,
        input  data_in,
        output periodo,
        output period_valid,
        output no_signal,
        output sign_out
    );

endinterface

// File: rtl/ffe_period_meter_hyst_sign.sv
// Hysteretic sign detector with a registered rising-edge pulse.
// With HYST=0 it reduces to the MSB sign (zero counts as positive).
module ffe_hyst_sign
    import ffe_pkg::*;
#(
    parameter int DATA_W = FFE_DATA_W,
    parameter int HYST   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_sign,
    output logic              o_rise
);

    localparam logic signed [DATA_W:0] LP_HI = (DATA_W+1)'(HYST);
    localparam logic signed [DATA_W:0] LP_LO = -LP_HI;

    logic signed [DATA_W:0] w_ext;
    logic                   w_set;
    logic                   w_clr;
    logic                   r_sign;
    logic                   r_sign_d;
    logic                   r_rise;

    assign w_ext = {i_data[DATA_W-1], i_data};

    // Decide whether the sample is clearly above or below the band.
    always_comb begin
        w_set = 1'b0;
        w_clr = 1'b0;
        if (HYST == 0) begin
            w_set = ~i_data[DATA_W-1];
            w_clr = i_data[DATA_W-1];
        end else begin
            w_set = (w_ext > LP_HI);
            w_clr = (w_ext < LP_LO);
        end
    end

    // Sign state holds inside the band; rise fires the cycle after it sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_sign_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            if (w_set) begin
                r_sign <= 1'b1;
            end else if (w_clr) begin
                r_sign <= 1'b0;
            end
            r_sign_d <= r_sign;
            r_rise   <= r_sign & ~r_sign_d;
        end
    end

    assign o_sign = r_sign;
    assign o_rise = r_rise;

endmodule

// File: rtl/ffe_period_meter.sv
// Full-period meter: rise-to-rise counter, glitch reject,
// power-of-two averager and loss-of-signal timeout.
module ffe_period_meter
    import ffe_pkg::*;
#(
    parameter int DATA_W     = FFE_DATA_W,
    parameter int CNT_W      = FFE_CNT_W,
    parameter int HYST       = 64,
    parameter int MIN_PERIOD = 16,
    parameter int MAX_PERIOD = 2**20,
    parameter int AVG_LOG2   = 0
) (
    input logic               CLK_IN,
    input logic               RST_N,
    ffe_period_meter_if.slave bus
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int NS_W  = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] LP_MIN  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [NS_W-1:0]  LP_NBLK = NS_W'(2**AVG_LOG2);
    localparam logic [NS_W-1:0]  LP_NONE = NS_W'(1);

    ffe_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [NS_W-1:0]   r_nsamp;
    logic [CNT_W-1:0]  r_periodo;
    logic              r_valid;
    logic              r_no_sig;

    logic              w_sign;
    logic              w_rise;
    logic              w_accept;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_sum_shr;
    logic [NS_W-1:0]   w_nsamp_nx;

    ffe_hyst_sign #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_sign (
        .clk    (CLK_IN),
        .rst_n  (RST_N),
        .i_data (bus.data_in),
        .o_sign (w_sign),
        .o_rise (w_rise)
    );

    assign w_accept   = w_rise & (r_cnt >= LP_MIN);
    assign w_sum      = r_acc + ACC_W'(r_cnt);
    assign w_sum_shr  = w_sum >> AVG_LOG2;
    assign w_nsamp_nx = r_nsamp + LP_NONE;

    // Measurement FSM: counts cycles between accepted rises and
    // publishes the block average once 2^AVG_LOG2 samples are in.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_nsamp   <= '0;
            r_periodo <= '0;
            r_valid   <= 1'b0;
            r_no_sig  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            if (!bus.enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_nsamp <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_cnt   <= LP_ONE;
                            r_state <= ST_MEASURE;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_accept) begin
                            // A rise on the timeout cycle still counts.
                            r_cnt <= LP_ONE;
                            if (w_nsamp_nx == LP_NBLK) begin
                                r_periodo <= w_sum_shr[CNT_W-1:0];
                                r_valid   <= 1'b1;
                                r_no_sig  <= 1'b0;
                                r_acc     <= '0;
                                r_nsamp   <= '0;
                            end else begin
                                r_acc   <= w_sum;
                                r_nsamp <= w_nsamp_nx;
                            end
                        end else if (r_cnt >= LP_MAX) begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_nsamp  <= '0;
                            r_no_sig <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + LP_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.periodo      = r_periodo;
    assign bus.period_valid = r_valid;
    assign bus.no_signal    = r_no_sig;
    assign bus.sign_out     = w_sign;

endmodule

// File: tb/tb_ffe_period_meter.sv
// Bench for ffe_period_meter: two instances (AVG_LOG2=0 and 2) fed
// the same stream, checked against a period-list reference model.
module tb_ffe_period_meter;

    localparam int MAXP = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [13:0] data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    longint exp_a[$];
    longint exp_b[$];
    longint got_a[$];
    longint got_b[$];

    int  cyc = 0;
    int  last_sign_cyc = -100;
    int  ns_cyc = -1;
    bit  sign_q = 1'b0;
    bit  ns_q = 1'b1;

    typedef struct {
        int p[4];
        int exp_b;
    } vec_t;

    vec_t tbl[4];

    ffe_period_meter_if #(.DATA_W(14), .CNT_W(32)) a_if ();
    ffe_period_meter_if #(.DATA_W(14), .CNT_W(32)) b_if ();

    assign a_if.enable  = enable;
    assign a_if.data_in = data;
    assign b_if.enable  = enable;
    assign b_if.data_in = data;

    ffe_period_meter #(
        .DATA_W(14), .CNT_W(32), .HYST(64),
        .MIN_PERIOD(16), .MAX_PERIOD(MAXP), .AVG_LOG2(0)
    ) dut_a (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .bus    (a_if)
    );

    ffe_period_meter #(
        .DATA_W(14), .CNT_W(32), .HYST(64),
        .MIN_PERIOD(16), .MAX_PERIOD(MAXP), .AVG_LOG2(2)
    ) dut_b (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .bus    (b_if)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    // Output monitor: collects results and checks output latency.
    always @(negedge clk) begin
        cyc++;
        if (a_if.sign_out && !sign_q) last_sign_cyc = cyc;
        sign_q = a_if.sign_out;
        if (a_if.no_signal && !ns_q) ns_cyc = cyc;
        ns_q = a_if.no_signal;
        if (a_if.period_valid) begin
            got_a.push_back(longint'(a_if.periodo));
            chk("valid_latency", cyc - last_sign_cyc, 2);
            chk("valid_clears_nosig", a_if.no_signal, 0);
        end
        if (b_if.period_valid) got_b.push_back(longint'(b_if.periodo));
    end

    task automatic step(input int v);
        data = 14'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int p, input bit gl);
        int v;
        for (int i = 0; i < p; i++) begin
            v = (i < p / 2) ? 4000 : -4000;
            if (gl && i >= 4 && i < 9) v = -4000;
            if (gl && i >= 70 && i < 75) v = 50;
            step(v);
        end
    endtask

    task automatic cmp_q(input string nm);
        int n;
        chk({nm, "_a_count"}, got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) chk({nm, "_a_periodo"}, got_a[i], exp_a[i]);
        chk({nm, "_b_count"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) chk({nm, "_b_periodo"}, got_b[i], exp_b[i]);
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    // Each enabled segment starts from scratch: first rise only arms,
    // every later rise closes one period; B averages groups of four.
    task automatic seg(input string nm, input int ps[$], input int gl, input int b_over);
        longint sum = 0;
        int k = 0;
        enable = 1'b1;
        repeat (20) step(-4000);
        foreach (ps[i]) begin
            drive_period(ps[i], (i == gl));
            exp_a.push_back(ps[i]);
            sum += ps[i];
            k++;
            if (k == 4) begin
                exp_b.push_back((b_over >= 0) ? longint'(b_over) : sum / 4);
                sum = 0;
                k = 0;
            end
        end
        repeat (50) step(4000);
        repeat (55) step(-4000);
        cmp_q(nm);
    endtask

    task automatic dis(input int n, input longint hold);
        enable = 1'b0;
        repeat (n) step(-4000);
        chk("dis_periodo_hold", a_if.periodo, hold);
        chk("dis_no_output", got_a.size() + got_b.size(), 0);
    endtask

    initial begin
        int ps[$];
        real x;
        int v;
        int n;

        tbl[0].p = '{100, 102, 98, 100};  tbl[0].exp_b = 100;
        tbl[1].p = '{101, 101, 101, 102}; tbl[1].exp_b = 101;
        tbl[2].p = '{16, 16, 16, 17};     tbl[2].exp_b = 16;
        tbl[3].p = '{MAXP, 300, 200, 150}; tbl[3].exp_b = 412;

        data = 14'(-4000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_periodo", a_if.periodo, 0);
        chk("rst_valid", a_if.period_valid, 0);
        chk("rst_no_signal", a_if.no_signal, 1);
        chk("rst_sign", a_if.sign_out, 0);
        rst_n = 1'b1;
        step(-4000);

        ps = '{100, 100, 100, 100};
        seg("lock", ps, -1, -1);
        dis(10, 100);

        foreach (tbl[t]) begin
            ps.delete();
            for (int i = 0; i < 4; i++) ps.push_back(tbl[t].p[i]);
            seg("table", ps, -1, tbl[t].exp_b);
            dis(10, tbl[t].p[3]);
        end

        ps = '{100, 100, 100, 100};
        seg("glitch", ps, 1, -1);
        dis(10, 100);

        ps.delete();
        for (int i = 0; i < 16; i++) ps.push_back(int'($urandom_range(400, 20)));
        seg("random", ps, -1, -1);
        dis(10, ps[15]);

        enable = 1'b1;
        repeat (20) step(-4000);
        drive_period(100, 1'b0);
        drive_period(100, 1'b0);
        for (int i = 0; i < 70; i++) step((i < 50) ? 4000 : -4000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_periodo", a_if.periodo, 0);
        chk("async_rst_valid", a_if.period_valid, 0);
        chk("async_rst_no_signal", a_if.no_signal, 1);
        chk("async_rst_sign", a_if.sign_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) step(-4000);
        exp_a.push_back(100);
        exp_a.push_back(100);
        cmp_q("midreset");
        dis(10, 0);

        enable = 1'b1;
        repeat (20) step(-4000);
        for (int t = 0; t < 2000; t++) begin
            x = 2000.0 * $sin(6.283185307179586 * t / 250.0);
            v = $rtoi(x) + int'($urandom_range(80)) - 40;
            step(v);
        end
        repeat (10) step(-4000);
        chk("sine_a_count", got_a.size(), 7);
        foreach (got_a[i]) begin
            n_tests++;
            if (got_a[i] < 249 || got_a[i] > 251) begin
                n_fail++;
                $display("FAIL sine_a_periodo: got %0d required 249..251", got_a[i]);
            end
        end
        chk("sine_b_count", got_b.size(), 1);
        foreach (got_b[i]) begin
            n_tests++;
            if (got_b[i] < 249 || got_b[i] > 251) begin
                n_fail++;
                $display("FAIL sine_b_periodo: got %0d required 249..251", got_b[i]);
            end
        end
        got_a.delete();
        got_b.delete();
        dis(10, a_if.periodo);

        enable = 1'b1;
        repeat (20) step(-4000);
        for (int i = 0; i < 3; i++) begin
            drive_period(100, 1'b0);
            exp_a.push_back(100);
        end
        repeat (50) step(4000);
        ns_cyc = -1;
        repeat (MAXP + 10) step(0);
        chk("timeout_latency", ns_cyc - last_sign_cyc, MAXP + 2);
        chk("timeout_no_signal", a_if.no_signal, 1);
        chk("timeout_periodo_hold", a_if.periodo, 100);
        cmp_q("timeout");

        repeat (20) step(-4000);
        for (int i = 0; i < 100; i++) begin
            step((i < 50) ? 4000 : -4000);
            if (i == 60) chk("recover_one_rise_nosig", a_if.no_signal, 1);
        end
        repeat (10) step(4000);
        chk("recover_no_signal", a_if.no_signal, 0);
        n = got_a.size();
        chk("recover_count", n, 1);
        if (n > 0) chk("recover_periodo", got_a[0], 100);
        repeat (40) step(4000);
        repeat (10) step(-4000);
        got_a.delete();
        got_b.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
